// File: rtl/glitch_seq_pkg.sv
// Shared types, LFSR polynomial and the per-bit fault function for glitch_sequencer.
package glitch_seq_pkg;

  typedef enum logic [1:0] {
    REPLACE = 2'b00,
    FLIP    = 2'b01,
    RANDOM  = 2'b10,
    STUCK   = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    DELAY,
    GLITCH,
    DONE
  } state_e;

  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

  // All fault modes are bitwise, so this is evaluated lane by lane across any WIDTH.
  function automatic logic fault_word(input mode_e mode, input logic din, input logic value,
                                      input logic mask, input logic rnd, input logic hold);
    logic res;
    case (mode)
      REPLACE: res = mask ? value : din;
      FLIP:    res = din ^ mask;
      RANDOM:  res = mask ? rnd : din;
      default: res = mask ? hold : din;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/glitch_lfsr.sv
// 32-bit Galois LFSR (right-shifting) that free-runs whenever reset is low.
module glitch_lfsr
  import glitch_seq_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_0001
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= (q >> 1) ^ (q[0] ? LFSR_POLY : 32'h0);
  end

endmodule

// File: rtl/glitch_sequencer.sv
// Inline multi-channel fault injector: registered passthrough with an armed, delayed,
// timed glitch window. Define GLITCH_SEQ_REPEAT_EN for repeated windows per arm.
//
// state  | meaning
// IDLE   | passthrough, waiting for arm (config latched on arm)
// ARMED  | config frozen, waiting for trigger
// DELAY  | counting down delay_cfg cycles
// GLITCH | out register takes faulted data, counting down duration
// DONE   | one-cycle done pulse, then IDLE
module glitch_sequencer
  import glitch_seq_pkg::*;
#(
  parameter int          WIDTH     = 32,
  parameter int          N_CH      = 4,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_CH*WIDTH-1:0] in,
  output logic [N_CH*WIDTH-1:0] out,
  input  logic                  arm,
  input  logic                  trigger,
  input  logic                  abort,
  input  logic [CNT_W-1:0]      delay_cfg,
  input  logic [CNT_W-1:0]      duration_cfg,
  input  logic [1:0]            mode_cfg,
  input  logic [WIDTH-1:0]      value_cfg,
  input  logic [WIDTH-1:0]      mask_cfg,
  input  logic [N_CH-1:0]       ch_sel_cfg,
`ifdef GLITCH_SEQ_REPEAT_EN
  input  logic [7:0]            repeat_cfg,
`endif
  output logic                  busy,
  output logic                  glitch_active,
  output logic                  done
);

  state_e             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [CNT_W-1:0]   delay_l, duration_l;
  mode_e              mode_l;
  logic [WIDTH-1:0]   value_l, mask_l;
  logic [N_CH-1:0]    ch_sel_l;
  logic [31:0]        lfsr_q;
  logic [WIDTH-1:0]   lfsr_w;
  logic [N_CH*WIDTH-1:0] rnd_all, out_nxt;
  logic               fire, latch_cfg;
`ifdef GLITCH_SEQ_REPEAT_EN
  logic [7:0]         rep_left, rep_left_nxt;
`endif

  glitch_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  // Replicate or truncate the LFSR word, then rotate per channel so channels differ.
  always_comb begin
    lfsr_w = '0;
    for (int i = 0; i < WIDTH; i++) lfsr_w[i] = lfsr_q[i % 32];
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_rot
    localparam int ROT = (k * 7) % WIDTH;
    assign rnd_all[k*WIDTH +: WIDTH] = (lfsr_w << ROT) | (lfsr_w >> (WIDTH - ROT));
  end

  assign fire      = (state == GLITCH) && !abort;
  assign latch_cfg = (state == IDLE) && arm && !abort;

  // STUCK holds masked bits by feeding the out register back into itself.
  always_comb begin
    out_nxt = in;
    for (int k = 0; k < N_CH; k++) begin
      for (int b = 0; b < WIDTH; b++) begin
        if (fire && ch_sel_l[k])
          out_nxt[k*WIDTH+b] = fault_word(mode_l, in[k*WIDTH+b], value_l[b], mask_l[b],
                                          rnd_all[k*WIDTH+b], out[k*WIDTH+b]);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
`ifdef GLITCH_SEQ_REPEAT_EN
    rep_left_nxt = rep_left;
`endif
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (arm) state_nxt = ARMED;
        ARMED: begin
          if (trigger) begin
            if (delay_l != '0) begin
              state_nxt = DELAY;
              cnt_nxt   = delay_l;
            end else if (duration_l != '0) begin
              state_nxt = GLITCH;
              cnt_nxt   = duration_l;
            end else begin
              state_nxt = DONE;
            end
          end
        end
        DELAY: begin
          if (cnt == CNT_W'(1)) begin
            if (duration_l != '0) begin
              state_nxt = GLITCH;
              cnt_nxt   = duration_l;
            end else begin
              state_nxt = DONE;
            end
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        GLITCH: begin
          if (cnt == CNT_W'(1)) begin
`ifdef GLITCH_SEQ_REPEAT_EN
            if (rep_left != 8'd0) begin
              rep_left_nxt = rep_left - 8'd1;
              if (delay_l != '0) begin
                state_nxt = DELAY;
                cnt_nxt   = delay_l;
              end else begin
                state_nxt = GLITCH;
                cnt_nxt   = duration_l;
              end
            end else begin
              state_nxt = DONE;
            end
`else
            state_nxt = DONE;
`endif
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      delay_l       <= '0;
      duration_l    <= '0;
      mode_l        <= REPLACE;
      value_l       <= '0;
      mask_l        <= '0;
      ch_sel_l      <= '0;
      out           <= '0;
      busy          <= 1'b0;
      glitch_active <= 1'b0;
      done          <= 1'b0;
`ifdef GLITCH_SEQ_REPEAT_EN
      rep_left      <= 8'd0;
`endif
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      out           <= out_nxt;
      busy          <= (state_nxt == ARMED) || (state_nxt == DELAY) || (state_nxt == GLITCH);
      glitch_active <= fire;
      done          <= (state == DONE) && !abort;
`ifdef GLITCH_SEQ_REPEAT_EN
      rep_left      <= latch_cfg ? repeat_cfg : rep_left_nxt;
`endif
      if (latch_cfg) begin
        delay_l    <= delay_cfg;
        duration_l <= duration_cfg;
        mode_l     <= mode_e'(mode_cfg);
        value_l    <= value_cfg;
        mask_l     <= mask_cfg;
        ch_sel_l   <= ch_sel_cfg;
      end
    end
  end

endmodule

// File: tb/tb_glitch_sequencer.sv
// Directed-vector bench for glitch_sequencer with an independent LFSR reference.
module tb_glitch_sequencer;

  localparam int WIDTH = 32;
  localparam int N_CH  = 4;
  localparam int CNT_W = 16;
  localparam logic [31:0] SEED = 32'hACE1_0001;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N_CH*WIDTH-1:0] in;
  logic [N_CH*WIDTH-1:0] out;
  logic                  arm, trigger, abort;
  logic [CNT_W-1:0]      delay_cfg, duration_cfg;
  logic [1:0]            mode_cfg;
  logic [WIDTH-1:0]      value_cfg, mask_cfg;
  logic [N_CH-1:0]       ch_sel_cfg;
  logic                  busy, glitch_active, done;
`ifdef GLITCH_SEQ_REPEAT_EN
  logic [7:0]            repeat_cfg = 8'd0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  glitch_sequencer #(.WIDTH(WIDTH), .N_CH(N_CH), .CNT_W(CNT_W), .LFSR_SEED(SEED)) dut (
    .clk           (clk),
    .reset         (reset),
    .in            (in),
    .out           (out),
    .arm           (arm),
    .trigger       (trigger),
    .abort         (abort),
    .delay_cfg     (delay_cfg),
    .duration_cfg  (duration_cfg),
    .mode_cfg      (mode_cfg),
    .value_cfg     (value_cfg),
    .mask_cfg      (mask_cfg),
    .ch_sel_cfg    (ch_sel_cfg),
`ifdef GLITCH_SEQ_REPEAT_EN
    .repeat_cfg    (repeat_cfg),
`endif
    .busy          (busy),
    .glitch_active (glitch_active),
    .done          (done)
  );

  always #5 clk = ~clk;

  // Reference LFSR; ref_prev is the word the DUT used at the most recent edge.
  logic [31:0] ref_lfsr, ref_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_lfsr <= SEED;
      ref_prev <= SEED;
    end else begin
      ref_lfsr <= (ref_lfsr >> 1) ^ (ref_lfsr[0] ? 32'h8020_0003 : 32'h0);
      ref_prev <= ref_lfsr;
    end
  end

  typedef struct {
    logic [1:0]  mode;
    int          delay;
    int          dur;
    logic [31:0] value;
    logic [31:0] mask;
    logic [3:0]  sel;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [31:0] rotl(input logic [31:0] w, input int r);
    return (w << r) | (w >> (32 - r));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic set_all_in(input logic [31:0] w);
    in = {N_CH{w}};
  endtask

  task automatic set_cfg(input vec_t v);
    mode_cfg     = v.mode;
    delay_cfg    = CNT_W'(v.delay);
    duration_cfg = CNT_W'(v.dur);
    value_cfg    = v.value;
    mask_cfg     = v.mask;
    ch_sel_cfg   = v.sel;
  endtask

  // Arm, trigger at edge T, then check edges T+1 .. T+delay+dur+2.
  task automatic run_window(input int idx, input vec_t v, input bit disturb);
    logic [31:0] e;
    set_all_in(v.din);
    set_cfg(v);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int j = 1; j <= v.delay + v.dur + 2; j++) begin
      if (disturb && j <= 2) begin
        arm = 1'b1;
        mode_cfg = 2'b01;
        delay_cfg = '0;
        duration_cfg = 16'd7;
        value_cfg = ~v.value;
        mask_cfg = '1;
        ch_sel_cfg = '1;
      end else begin
        arm = 1'b0;
      end
      tick();
      for (int k = 0; k < N_CH; k++) begin
        e = (j >= v.delay + 1 && j <= v.delay + v.dur && v.sel[k]) ? v.exp : v.din;
        chk($sformatf("v%0d j%0d out ch%0d", idx, j, k), out[k*WIDTH +: WIDTH], e);
      end
      chk($sformatf("v%0d j%0d glitch_active", idx, j), 32'(glitch_active),
          32'(j >= v.delay + 1 && j <= v.delay + v.dur));
      chk($sformatf("v%0d j%0d done", idx, j), 32'(done), 32'(j == v.delay + v.dur + 1));
      chk($sformatf("v%0d j%0d busy", idx, j), 32'(busy), 32'(j < v.delay + v.dur));
    end
    arm = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'b00, 3, 2, 32'hDEAD_BEEF, 32'hFFFF_0000, 4'b0010, 32'h1234_5678, 32'hDEAD_5678};
    vecs[1] = '{2'b01, 0, 1, 32'h0,         32'h0000_0001, 4'b1111, 32'h1234_5678, 32'h1234_5679};
    vecs[2] = '{2'b00, 0, 0, 32'h0,         32'hFFFF_FFFF, 4'b1111, 32'h1234_5678, 32'h1234_5678};
    vecs[3] = '{2'b01, 2, 3, 32'h0,         32'h0F0F_0F0F, 4'b0101, 32'hA5A5_A5A5, 32'hAAAA_AAAA};
    vecs[4] = '{2'b00, 1, 1, 32'h0000_FFFF, 32'h00FF_00FF, 4'b1000, 32'h1234_5678, 32'h1200_56FF};
    vecs[5] = '{2'b01, 2, 0, 32'h0,         32'h0000_00FF, 4'b1111, 32'h1234_5678, 32'h1234_5678};

    reset = 1'b1;
    arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    in = '0;
    set_cfg(vecs[2]);
    tick();
    set_all_in(32'h1234_5678);
    tick();
    chk("reset out", out[31:0], 32'h0);
    chk("reset busy", 32'(busy), 32'h0);
    chk("reset glitch_active", 32'(glitch_active), 32'h0);
    chk("reset done", 32'(done), 32'h0);

    reset = 1'b0;
    tick();
    for (int k = 0; k < N_CH; k++)
      chk($sformatf("passthrough ch%0d", k), out[k*WIDTH +: WIDTH], 32'h1234_5678);
    chk("passthrough busy", 32'(busy), 32'h0);

    trigger = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("idle trigger busy", 32'(busy), 32'h0);
      chk("idle trigger glitch", 32'(glitch_active), 32'h0);
      chk("idle trigger out", out[63:32], 32'h1234_5678);
    end
    trigger = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_window(i, vecs[i], 1'b0);

    // arm and cfg changes during DELAY must not alter the window
    run_window(10, vecs[0], 1'b1);
    tick();

    // STUCK: masked upper half holds 0F0F while in toggles
    set_all_in(32'h0F0F_0F0F);
    mode_cfg = 2'b11; delay_cfg = 16'd1; duration_cfg = 16'd3;
    mask_cfg = 32'hFFFF_0000; ch_sel_cfg = 4'b1111; value_cfg = 32'h0;
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    chk("stuck pre out", out[31:0], 32'h0F0F_0F0F);
    set_all_in(32'hFFFF_FFFF); tick();
    chk("stuck g1 ch0", out[31:0], 32'h0F0F_FFFF);
    chk("stuck g1 ch3", out[127:96], 32'h0F0F_FFFF);
    set_all_in(32'h0000_0000); tick();
    chk("stuck g2 ch2", out[95:64], 32'h0F0F_0000);
    set_all_in(32'hFFFF_FFFF); tick();
    chk("stuck g3 ch1", out[63:32], 32'h0F0F_FFFF);
    chk("stuck g3 glitch_active", 32'(glitch_active), 32'h1);
    set_all_in(32'h1234_5678); tick();
    chk("stuck end out", out[31:0], 32'h1234_5678);
    chk("stuck end done", 32'(done), 32'h1);
    chk("stuck end glitch_active", 32'(glitch_active), 32'h0);
    tick();

    // abort during DELAY: no glitch, no done
    set_all_in(32'h1234_5678);
    mode_cfg = 2'b00; delay_cfg = 16'd5; duration_cfg = 16'd2;
    mask_cfg = 32'hFFFF_FFFF; value_cfg = 32'h0; ch_sel_cfg = 4'b1111;
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick(); tick();
    chk("abort pre busy", 32'(busy), 32'h1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort busy", 32'(busy), 32'h0);
    for (int j = 0; j < 8; j++) begin
      tick();
      chk($sformatf("abort j%0d out", j), out[31:0], 32'h1234_5678);
      chk($sformatf("abort j%0d glitch", j), 32'(glitch_active), 32'h0);
      chk($sformatf("abort j%0d done", j), 32'(done), 32'h0);
    end

    // asynchronous reset in the middle of a FLIP window
    mode_cfg = 2'b01; delay_cfg = 16'd0; duration_cfg = 16'd5;
    mask_cfg = 32'hFFFF_FFFF; ch_sel_cfg = 4'b1111;
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    tick();
    chk("rst pre glitch out", out[31:0], 32'hEDCB_A987);
    #2 reset = 1'b1;
    #1;
    chk("rst async out", out[31:0], 32'h0);
    chk("rst async busy", 32'(busy), 32'h0);
    chk("rst async glitch", 32'(glitch_active), 32'h0);
    tick();
    reset = 1'b0;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk($sformatf("rst post j%0d done", j), 32'(done), 32'h0);
      chk($sformatf("rst post j%0d out", j), out[31:0], 32'h1234_5678);
    end
    run_window(20, vecs[0], 1'b0);

    // RANDOM with full mask tracks the reference LFSR, rotated by 7*k per channel
    mode_cfg = 2'b10; delay_cfg = 16'd0; duration_cfg = 16'd4;
    mask_cfg = 32'hFFFF_FFFF; ch_sel_cfg = 4'b1111;
    arm = 1'b1; tick(); arm = 1'b0;
    trigger = 1'b1; tick(); trigger = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      tick();
      for (int k = 0; k < N_CH; k++)
        chk($sformatf("random j%0d ch%0d", j, k), out[k*WIDTH +: WIDTH], rotl(ref_prev, 7 * k));
    end
    tick();
    chk("random end done", 32'(done), 32'h1);
    chk("random end out", out[31:0], 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
